// File: rtl/exh_pkg.sv
// Shared types for the exhaustive vector engine.
// Holds the sequencer state encoding and the default MISR polynomial.
package exh_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CAPTURE,
        S_EMIT,
        S_DONE
    } exh_state_e;

    localparam logic [15:0] EXH_POLY_DEFAULT = 16'h1021;

endpackage

// File: rtl/exh_misr.sv
// Multiple-input signature register.
// Folds one data word per enabled cycle into the running signature.
module exh_misr
    import exh_pkg::*;
#(
    parameter int                 MISR_W = 16,
    parameter logic [MISR_W-1:0]  POLY   = MISR_W'(EXH_POLY_DEFAULT)
) (
    input  logic              CK,
    input  logic              clear,
    input  logic              enable,
    input  logic [MISR_W-1:0] data_in,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] sig_q;
    logic [MISR_W-1:0] sig_d;

    // Next signature: clear wins, otherwise shift, feed back and fold data.
    always_comb begin
        sig_d = sig_q;
        if (clear) begin
            sig_d = '0;
        end else if (enable) begin
            sig_d = (sig_q << 1)
                  ^ (sig_q[MISR_W-1] ? POLY : '0)
                  ^ data_in;
        end
    end

    // Signature register.
    always_ff @(posedge CK) begin
        sig_q <= sig_d;
    end

    assign sig = sig_q;

endmodule

// File: rtl/exhaustive_vector_engine.sv
// Exhaustive pattern sweeper: applies every N_IN-bit pattern in order,
// samples the response, streams records and compacts them into a MISR.
module exhaustive_vector_engine
    import exh_pkg::*;
#(
    parameter int                N_IN    = 2,
    parameter int                N_OUT   = 1,
    parameter int                SETTLE  = 1,
    parameter int                MISR_W  = 16,
    parameter logic [MISR_W-1:0] POLY    = MISR_W'(EXH_POLY_DEFAULT),
    parameter bit                EMIT_EN = 1'b1
) (
    input  logic                  CK,
    input  logic                  reset,
    input  logic                  start,
    output logic [N_IN-1:0]       dut_in,
    input  logic [N_OUT-1:0]      dut_out,
    output logic                  rec_valid,
    input  logic                  rec_ready,
    output logic [N_IN+N_OUT-1:0] rec_data,
    output logic                  busy,
    output logic                  done,
    output logic [MISR_W-1:0]     signature
);

    localparam int         REC_W       = N_IN + N_OUT;
    localparam logic [7:0] SETTLE_LAST = (SETTLE > 0) ? 8'(SETTLE - 1) : 8'd0;

    exh_state_e        state_q, state_d;
    logic [N_IN-1:0]   pattern_q, pattern_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [REC_W-1:0]  rec_q, rec_d;
    logic              advance;
    logic              misr_clear;
    logic              misr_en;
    logic [MISR_W-1:0] misr_din;

    // Zero-extend the record into the signature width.
    always_comb begin
        misr_din = '0;
        misr_din[REC_W-1:0] = {pattern_q, dut_out};
    end

    // Sequencer next-state, pattern stepping and capture control.
    always_comb begin
        state_d    = state_q;
        pattern_d  = pattern_q;
        cnt_d      = cnt_q;
        rec_d      = rec_q;
        advance    = 1'b0;
        misr_clear = reset;
        misr_en    = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_APPLY;
                    pattern_d  = '0;
                    misr_clear = 1'b1;
                end
            end
            S_APPLY: begin
                cnt_d   = 8'd0;
                state_d = (SETTLE == 0) ? S_CAPTURE : S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_CAPTURE: begin
                rec_d   = {pattern_q, dut_out};
                misr_en = 1'b1;
                if (EMIT_EN) begin
                    state_d = S_EMIT;
                end else begin
                    advance = 1'b1;
                end
            end
            S_EMIT: begin
                advance = rec_ready;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (advance) begin
            if (&pattern_q) begin
                state_d = S_DONE;
            end else begin
                pattern_d = pattern_q + 1'b1;
                state_d   = S_APPLY;
            end
        end
    end

    // State, pattern, settle counter and record registers.
    always_ff @(posedge CK) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pattern_q <= '0;
            cnt_q     <= 8'd0;
            rec_q     <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            cnt_q     <= cnt_d;
            rec_q     <= rec_d;
        end
    end

    exh_misr #(
        .MISR_W (MISR_W),
        .POLY   (POLY)
    ) u_misr (
        .CK      (CK),
        .clear   (misr_clear),
        .enable  (misr_en),
        .data_in (misr_din),
        .sig     (signature)
    );

    assign dut_in    = pattern_q;
    assign rec_valid = (state_q == S_EMIT);
    assign rec_data  = rec_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_exhaustive_vector_engine.sv
// Randomised self-checking bench for exhaustive_vector_engine.
// Instance A uses defaults; instance B is signature-only, SETTLE=0, N_IN=3.
module tb_exhaustive_vector_engine;

    logic        CK;
    logic        reset;
    logic        start_a, start_b;
    logic [1:0]  dut_in_a;
    logic [2:0]  dut_in_b;
    logic        dut_out_a, dut_out_b;
    logic        rec_valid_a, rec_valid_b;
    logic        rec_ready_a, rec_ready_b;
    logic [2:0]  rec_data_a;
    logic [3:0]  rec_data_b;
    logic        busy_a, busy_b;
    logic        done_a, done_b;
    logic [15:0] sig_a, sig_b;

    int checks = 0;
    int errors = 0;

    assign dut_out_a = &dut_in_a;
    assign dut_out_b = &dut_in_b;

    exhaustive_vector_engine u_a (
        .CK        (CK),
        .reset     (reset),
        .start     (start_a),
        .dut_in    (dut_in_a),
        .dut_out   (dut_out_a),
        .rec_valid (rec_valid_a),
        .rec_ready (rec_ready_a),
        .rec_data  (rec_data_a),
        .busy      (busy_a),
        .done      (done_a),
        .signature (sig_a)
    );

    exhaustive_vector_engine #(
        .N_IN    (3),
        .SETTLE  (0),
        .EMIT_EN (1'b0)
    ) u_b (
        .CK        (CK),
        .reset     (reset),
        .start     (start_b),
        .dut_in    (dut_in_b),
        .dut_out   (dut_out_b),
        .rec_valid (rec_valid_b),
        .rec_ready (rec_ready_b),
        .rec_data  (rec_data_b),
        .busy      (busy_b),
        .done      (done_b),
        .signature (sig_b)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Record for pattern p of an AND-gate DUT: {p, &p}.
    function automatic int model_rec(input int p, input int n_in);
        return p * 2 + ((p == (1 << n_in) - 1) ? 1 : 0);
    endfunction

    // Expected signature after a full ascending sweep.
    function automatic int model_sig(input int n_in);
        int s = 0;
        for (int p = 0; p < (1 << n_in); p++) begin
            int msb = (s >> 15) & 1;
            s = ((s * 2) & 16'hffff) ^ (msb ? 16'h1021 : 0) ^ model_rec(p, n_in);
        end
        return s;
    endfunction

    // mode 0: ready=1; 1: 5-cycle stall on second record; 2: random ready and start.
    task automatic sweep_a(input int mode);
        int   exp_q[$];
        int   rec_idx = 0;
        int   stall_left = 0;
        int   stalls = 0;
        int   busy_cyc = 0;
        bit   holding = 0;
        bit   rdy;
        logic [2:0] held = '0;
        for (int p = 0; p < 4; p++) exp_q.push_back(model_rec(p, 2));
        start_a = 1'b1;
        @(negedge CK);
        start_a = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (done_a) break;
            if (busy_a) busy_cyc++;
            rdy = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rec_valid_a) begin
                if (!holding) begin
                    if (exp_q.size() == 0) begin
                        check("extra_rec", 1, 0);
                    end else begin
                        check("rec_data", rec_data_a, exp_q[0]);
                    end
                    held = rec_data_a;
                    holding = 1'b1;
                    if (mode == 1 && rec_idx == 1) stall_left = 5;
                end else begin
                    check("rec_hold", rec_data_a, held);
                end
                if (mode == 1) rdy = (stall_left == 0);
                if (stall_left > 0) stall_left--;
                if (!rdy) begin
                    stalls++;
                end else begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    rec_idx++;
                    holding = 1'b0;
                end
            end else if (holding) begin
                check("valid_drop", 0, 1);
                holding = 1'b0;
            end
            start_a = (mode == 2) ? ($urandom_range(0, 5) == 0) : 1'b0;
            rec_ready_a = rdy;
            @(negedge CK);
        end
        start_a = 1'b0;
        rec_ready_a = 1'b1;
        check("done", done_a, 1);
        check("busy_end", busy_a, 0);
        check("busy_cyc", busy_cyc, 16 + stalls);
        if (mode == 1) check("stall_cnt", stalls, 5);
        check("sig_a", sig_a, model_sig(2));
        check("recs_left", exp_q.size(), 0);
        check("dut_in_done", dut_in_a, 3);
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_dut_in"}, dut_in_a, 0);
        check({tag, "_valid"}, rec_valid_a, 0);
        check({tag, "_data"}, rec_data_a, 0);
        check({tag, "_busy"}, busy_a, 0);
        check({tag, "_done"}, done_a, 0);
        check({tag, "_sig"}, sig_a, 0);
    endtask

    initial begin
        int seen;
        int busy_cyc;
        reset = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        rec_ready_a = 1'b1;
        rec_ready_b = 1'b1;
        repeat (3) @(negedge CK);
        check_a_zero("rst_a");
        check("rst_b_busy", busy_b, 0);
        check("rst_b_sig", sig_b, 0);
        reset = 1'b0;
        @(negedge CK);

        sweep_a(0);
        sweep_a(1);
        for (int r = 0; r < 6; r++) sweep_a(2);

        start_a = 1'b1;
        @(negedge CK);
        start_a = 1'b0;
        check("restart_done_clr", done_a, 0);
        check("restart_busy", busy_a, 1);
        check("restart_pat", dut_in_a, 0);

        seen = 0;
        for (int t = 0; t < 100; t++) begin
            if (rec_valid_a) seen++;
            if (seen == 3) break;
            @(negedge CK);
        end
        check("third_rec_seen", seen, 3);
        check("third_rec_data", rec_data_a, model_rec(2, 2));
        reset = 1'b1;
        rec_ready_a = 1'b0;
        @(negedge CK);
        reset = 1'b0;
        rec_ready_a = 1'b1;
        check_a_zero("midrst");
        @(negedge CK);
        check("midrst_idle", busy_a, 0);
        sweep_a(0);

        reset = 1'b1;
        start_a = 1'b1;
        @(negedge CK);
        reset = 1'b0;
        start_a = 1'b0;
        check_a_zero("rst_prio");

        start_b = 1'b1;
        @(negedge CK);
        start_b = 1'b0;
        busy_cyc = 0;
        for (int t = 0; t < 100; t++) begin
            if (done_b) break;
            check("b_valid", rec_valid_b, 0);
            if (busy_b) begin
                check("b_dut_in", dut_in_b, busy_cyc / 2);
                busy_cyc++;
            end
            @(negedge CK);
        end
        check("b_done", done_b, 1);
        check("b_busy_cyc", busy_cyc, 16);
        check("b_sig", sig_b, model_sig(3));
        check("b_dut_in_done", dut_in_b, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
